afe_inj_seq: RTL

- Sequences charge injection into the analog front end and measures the comparator response.
- Generates a programmable train of INJ pulses and synchronises the asynchronous COMP input.
- For each comparator firing, raises HIT, counts hits and measures time-over-threshold (ToT) in CLK cycles.
- Sits between the SPI register block (which supplies configuration and START/ABORT) and the AFE INJ/COMP pins.

---
 rtl/afe_inj_seq_pkg.sv | 17 +
 rtl/afe_inj_seq_if.sv | 35 +++
 rtl/afe_comp_sync.sv | 32 +++
 rtl/afe_inj_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/afe_inj_seq_pkg.sv
// Shared types and default widths for the AFE injection sequencer and
// its comparator synchroniser.
package afe_inj_seq_pkg;

  localparam int DEF_CFG_W   = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TOT_W   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE_HI = 2'd1,
    ST_PULSE_LO = 2'd2,
    ST_FINISH   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/afe_inj_seq_if.sv
// Control/configuration and AFE pin bundle between the register block
// (master) and the injection sequencer (slave).
interface afe_inj_seq_if
  import afe_inj_seq_pkg::*;
#(
  parameter int CFG_W = DEF_CFG_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOT_W = DEF_TOT_W
);

  logic             start;
  logic             abort;
  logic [CFG_W-1:0] n_inj;
  logic [CFG_W-1:0] inj_high;
  logic [CFG_W-1:0] inj_period;
  logic             comp;
  logic             inj;
  logic             hit;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;
  logic [TOT_W-1:0] tot;
  logic             tot_valid;

  modport master (
    output start, abort, n_inj, inj_high, inj_period, comp,
    input  inj, hit, busy, done, hit_cnt, tot, tot_valid
  );

  modport slave (
    input  start, abort, n_inj, inj_high, inj_period, comp,
    output inj, hit, busy, done, hit_cnt, tot, tot_valid
  );

endinterface

// File: rtl/afe_comp_sync.sv
// Brings the asynchronous comparator output into the clock domain and
// derives its level plus single-cycle rise/fall strobes.
module afe_comp_sync
  import afe_inj_seq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Synchroniser chain; the extra history flop gives edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/afe_inj_seq.sv
// Charge-injection sequencer: issues a latched train of INJ pulses and
// counts/measures the synchronised comparator response.
module afe_inj_seq
  import afe_inj_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOT_W = DEF_TOT_W,
  parameter int CFG_W = DEF_CFG_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  afe_inj_seq_if.slave io_bus
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CFG_W-1:0] r_n_inj;
  logic [CFG_W-1:0] r_hi;
  logic [CFG_W-1:0] r_lo;
  logic [CFG_W-1:0] r_tcnt;
  logic [CFG_W-1:0] r_pcnt;
  logic [CFG_W-1:0] w_tcnt_nxt;
  logic [CFG_W-1:0] w_pcnt_nxt;
  logic [CFG_W-1:0] w_hi_eff;
  logic [CFG_W-1:0] w_lo_eff;
  logic             r_start_pend;
  logic             w_pend_nxt;
  logic             w_latch;
  logic             w_clr_cnt;
  logic             r_inj;
  logic             r_busy;
  logic             r_done;
  logic             w_inj_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             r_hit;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [TOT_W-1:0] r_tot_cnt;
  logic [TOT_W-1:0] r_tot;
  logic             r_tot_valid;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;

  afe_comp_sync u_comp_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (io_bus.comp),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Effective timing: high time at least 1, low time at least 1.
  always_comb begin
    w_hi_eff = io_bus.inj_high;
    w_lo_eff = CFG_W'(1);
    if (io_bus.inj_high == '0) begin
      w_hi_eff = CFG_W'(1);
    end else begin
      w_hi_eff = io_bus.inj_high;
    end
    if (io_bus.inj_period > w_hi_eff) begin
      w_lo_eff = io_bus.inj_period - w_hi_eff;
    end else begin
      w_lo_eff = CFG_W'(1);
    end
  end

  // Next-state and next-output logic; ABORT overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_pcnt_nxt  = r_pcnt;
    w_inj_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_pend_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_clr_cnt   = 1'b0;
    if (io_bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_start_pend) begin
            w_clr_cnt = 1'b1;
            if (r_n_inj == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_PULSE_HI;
              w_inj_nxt   = 1'b1;
              w_busy_nxt  = 1'b1;
              w_tcnt_nxt  = CFG_W'(1);
              w_pcnt_nxt  = CFG_W'(1);
            end
          end else if (io_bus.start) begin
            w_pend_nxt = 1'b1;
            w_latch    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PULSE_HI: begin
          w_busy_nxt = 1'b1;
          if (r_tcnt >= r_hi) begin
            w_state_nxt = ST_PULSE_LO;
            w_tcnt_nxt  = CFG_W'(1);
          end else begin
            w_inj_nxt  = 1'b1;
            w_tcnt_nxt = r_tcnt + CFG_W'(1);
          end
        end
        ST_PULSE_LO: begin
          if (r_tcnt < r_lo) begin
            w_busy_nxt = 1'b1;
            w_tcnt_nxt = r_tcnt + CFG_W'(1);
          end else if (r_pcnt < r_n_inj) begin
            w_state_nxt = ST_PULSE_HI;
            w_inj_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
            w_tcnt_nxt  = CFG_W'(1);
            w_pcnt_nxt  = r_pcnt + CFG_W'(1);
          end else begin
            w_state_nxt = ST_FINISH;
            w_done_nxt  = 1'b1;
          end
        end
        ST_FINISH: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state, phase counters, latched configuration and pin outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_tcnt       <= '0;
      r_pcnt       <= '0;
      r_start_pend <= 1'b0;
      r_n_inj      <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_inj        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_start_pend <= w_pend_nxt;
      r_inj        <= w_inj_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      if (w_latch) begin
        r_n_inj <= io_bus.n_inj;
        r_hi    <= w_hi_eff;
        r_lo    <= w_lo_eff;
      end
    end
  end

  // Hit counting is gated by BUSY; ToT measurement runs regardless of the run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit       <= 1'b0;
      r_hit_cnt   <= '0;
      r_tot_cnt   <= '0;
      r_tot       <= '0;
      r_tot_valid <= 1'b0;
    end else begin
      r_hit <= w_rise & r_busy;
      if (w_clr_cnt) begin
        r_hit_cnt <= '0;
      end else if (w_rise && r_busy && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end else begin
        r_hit_cnt <= r_hit_cnt;
      end
      if (w_rise) begin
        r_tot_cnt <= TOT_W'(1);
      end else if (w_level && (r_tot_cnt != '1)) begin
        r_tot_cnt <= r_tot_cnt + TOT_W'(1);
      end else begin
        r_tot_cnt <= r_tot_cnt;
      end
      if (w_fall) begin
        r_tot       <= r_tot_cnt;
        r_tot_valid <= 1'b1;
      end else begin
        r_tot_valid <= 1'b0;
      end
    end
  end

  assign io_bus.inj       = r_inj;
  assign io_bus.hit       = r_hit;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.hit_cnt   = r_hit_cnt;
  assign io_bus.tot       = r_tot;
  assign io_bus.tot_valid = r_tot_valid;

endmodule
